// File: rtl/id_ex_issue_if.sv
// Fetch, writeback and ID/EX bundle for the decode/issue stage.
// slave is the stage itself; master is whatever drives fetch and writeback.
interface id_ex_issue_if #(
  parameter int XLEN = 32
);
  logic [31:0]     if_instr;
  logic            if_valid;
  logic            if_ready;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            id_ex_enable;
  logic [3:0]      id_ex_alu_control;
  logic [4:0]      id_ex_rd;
  logic            id_ex_mul;
  logic            illegal;

  modport slave (
    input  if_instr, if_valid, wb_en, wb_rd, wb_data,
    output if_ready, in1, in2, id_ex_enable, id_ex_alu_control, id_ex_rd, id_ex_mul, illegal
  );

  modport master (
    output if_instr, if_valid, wb_en, wb_rd, wb_data,
    input  if_ready, in1, in2, id_ex_enable, id_ex_alu_control, id_ex_rd, id_ex_mul, illegal
  );
endinterface

// File: rtl/id_ex_issue.sv
// Decode/issue stage: RV32I OP/OP-IMM plus MUL, local register file,
// per-register pending scoreboard with RAW stall and a registered ID/EX boundary.
module id_ex_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_issue_if.slave bus
);
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  localparam logic [1:0] SRC_REG   = 2'd0;
  localparam logic [1:0] SRC_SIMM  = 2'd1;
  localparam logic [1:0] SRC_SHAMT = 2'd2;

  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_sb;
  logic [XLEN-1:0] r_in1, r_in2;
  logic [3:0]      r_alu;
  logic [4:0]      r_rd;
  logic            r_mul, r_en, r_ill;

  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic            w_legal, w_uses_rs2;
  logic [3:0]      w_alu;
  logic [1:0]      w_src2;
  logic [XLEN-1:0] w_op1, w_rs2_val, w_op2;
  logic            w_wb_clr, w_pend1, w_pend2, w_stall, w_accept, w_issue;
  logic [NREG-1:0] w_clr_mask, w_set_mask;

  assign w_opcode = bus.if_instr[6:0];
  assign w_rd     = bus.if_instr[11:7];
  assign w_funct3 = bus.if_instr[14:12];
  assign w_rs1    = bus.if_instr[19:15];
  assign w_rs2    = bus.if_instr[24:20];
  assign w_funct7 = bus.if_instr[31:25];

  // Instruction decode: legality, ALU operation and operand-2 source.
  always_comb begin
    w_legal    = 1'b0;
    w_alu      = ALU_ADD;
    w_uses_rs2 = 1'b0;
    w_src2     = SRC_REG;
    case (w_opcode)
      OPC_OP: begin
        w_uses_rs2 = 1'b1;
        case (w_funct7)
          7'b0000000: begin
            w_legal = 1'b1;
            case (w_funct3)
              3'b000:  w_alu = ALU_ADD;
              3'b001:  w_alu = ALU_SLL;
              3'b010:  w_alu = ALU_SLT;
              3'b011:  w_alu = ALU_SLTU;
              3'b100:  w_alu = ALU_XOR;
              3'b101:  w_alu = ALU_SRL;
              3'b110:  w_alu = ALU_OR;
              default: w_alu = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (w_funct3 == 3'b000) begin
              w_legal = 1'b1;
              w_alu   = ALU_SUB;
            end else if (w_funct3 == 3'b101) begin
              w_legal = 1'b1;
              w_alu   = ALU_SRA;
            end else begin
              w_legal = 1'b0;
            end
          end
          7'b0000001: begin
            w_legal = (w_funct3 == 3'b000);
            w_alu   = ALU_MUL;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_IMM: begin
        w_legal = 1'b1;
        w_src2  = SRC_SIMM;
        case (w_funct3)
          3'b000: w_alu = ALU_ADD;
          3'b010: w_alu = ALU_SLT;
          3'b011: w_alu = ALU_SLTU;
          3'b100: w_alu = ALU_XOR;
          3'b110: w_alu = ALU_OR;
          3'b111: w_alu = ALU_AND;
          3'b001: begin
            w_src2  = SRC_SHAMT;
            w_alu   = ALU_SLL;
            w_legal = (w_funct7 == 7'b0000000);
          end
          default: begin
            w_src2 = SRC_SHAMT;
            if (w_funct7 == 7'b0000000) begin
              w_alu = ALU_SRL;
            end else if (w_funct7 == 7'b0100000) begin
              w_alu = ALU_SRA;
            end else begin
              w_legal = 1'b0;
            end
          end
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Same-cycle writeback is bypassed so a just-cleared source never reads stale data.
  assign w_op1 = (w_rs1 == 5'd0) ? {XLEN{1'b0}} :
                 (bus.wb_en && (bus.wb_rd == w_rs1)) ? bus.wb_data : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? {XLEN{1'b0}} :
                     (bus.wb_en && (bus.wb_rd == w_rs2)) ? bus.wb_data : r_rf[w_rs2];

  // Operand-2 select between register, sign-extended immediate and shift amount.
  always_comb begin
    case (w_src2)
      SRC_SIMM:  w_op2 = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]};
      SRC_SHAMT: w_op2 = {{(XLEN-5){1'b0}}, bus.if_instr[24:20]};
      default:   w_op2 = w_rs2_val;
    endcase
  end

  assign w_wb_clr = bus.wb_en && (bus.wb_rd != 5'd0);
  assign w_pend1  = r_sb[w_rs1] && !(w_wb_clr && (bus.wb_rd == w_rs1));
  assign w_pend2  = r_sb[w_rs2] && !(w_wb_clr && (bus.wb_rd == w_rs2));
  // Illegal encodings never stall: they are always swallowed.
  assign w_stall  = bus.if_valid && w_legal && (w_pend1 || (w_uses_rs2 && w_pend2));
  assign w_accept = bus.if_valid && !w_stall;
  assign w_issue  = w_accept && w_legal;

  assign w_clr_mask = w_wb_clr ? ({{(NREG-1){1'b0}}, 1'b1} << bus.wb_rd) : {NREG{1'b0}};
  assign w_set_mask = (w_issue && (w_rd != 5'd0)) ? ({{(NREG-1){1'b0}}, 1'b1} << w_rd)
                                                  : {NREG{1'b0}};

  // Register file write and scoreboard update; an issue set beats a writeback clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= {XLEN{1'b0}};
      end
      r_sb <= {NREG{1'b0}};
    end else begin
      if (w_wb_clr) begin
        r_rf[bus.wb_rd] <= bus.wb_data;
      end
      r_sb <= (r_sb & ~w_clr_mask) | w_set_mask;
    end
  end

  // ID/EX boundary: load on legal issue, otherwise hold with enable low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in1 <= {XLEN{1'b0}};
      r_in2 <= {XLEN{1'b0}};
      r_alu <= 4'd0;
      r_rd  <= 5'd0;
      r_mul <= 1'b0;
      r_en  <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      r_en  <= w_issue;
      r_ill <= w_accept && !w_legal;
      if (w_issue) begin
        r_in1 <= w_op1;
        r_in2 <= w_op2;
        r_alu <= w_alu;
        r_rd  <= w_rd;
        r_mul <= (w_alu == ALU_MUL);
      end
    end
  end

  assign bus.if_ready          = !w_stall;
  assign bus.in1               = r_in1;
  assign bus.in2               = r_in2;
  assign bus.id_ex_enable      = r_en;
  assign bus.id_ex_alu_control = r_alu;
  assign bus.id_ex_rd          = r_rd;
  assign bus.id_ex_mul         = r_mul;
  assign bus.illegal           = r_ill;
endmodule
